// File: rtl/intcalc_multicycle_pkg.sv
// Shared types for the bexkat1 integer calculation units.
// intfunc_t selects the operation; intcalc_state_t is the multicycle FSM.
package bexkat1Def;

    typedef enum logic [3:0] {
        INT_MUL   = 4'h0,
        INT_DIV   = 4'h1,
        INT_MOD   = 4'h2,
        INT_MULU  = 4'h3,
        INT_DIVU  = 4'h4,
        INT_MODU  = 4'h5,
        INT_MULX  = 4'h6,
        INT_MULUX = 4'h7,
        INT_EXT   = 4'h8,
        INT_EXTB  = 4'h9,
        INT_COM   = 4'ha,
        INT_NEG   = 4'hb
    } intfunc_t;

    typedef enum logic [2:0] {
        IDLE,
        MUL,
        DIV,
        FIX,
        DONE
    } intcalc_state_t;

endpackage

// File: rtl/intcalc_divider.sv
// Unsigned restoring divider, one quotient bit per cycle, WIDTH cycles.
// Ports: clk_i, rst_i (async low), start_i, dividend_i, divisor_i,
//        busy_o, done_o (last iteration this cycle), quotient_o, remainder_o.
module intcalc_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] div_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;

    // Quotient register doubles as the dividend shifter.
    assign shifted = {rem_q, quo_q[WIDTH-1]};
    assign diff    = shifted - {1'b0, div_q};

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            quo_q  <= '0;
            rem_q  <= '0;
            div_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else if (start_i) begin
            quo_q  <= dividend_i;
            rem_q  <= '0;
            div_q  <= divisor_i;
            cnt_q  <= '0;
            busy_q <= 1'b1;
        end else if (busy_q) begin
            cnt_q <= cnt_q + 1'b1;
            if (!diff[WIDTH]) begin
                rem_q <= diff[WIDTH-1:0];
                quo_q <= {quo_q[WIDTH-2:0], 1'b1};
            end else begin
                rem_q <= shifted[WIDTH-1:0];
                quo_q <= {quo_q[WIDTH-2:0], 1'b0};
            end
            if (cnt_q == LAST) begin
                busy_q <= 1'b0;
            end
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = busy_q && (cnt_q == LAST);
    assign quotient_o  = quo_q;
    assign remainder_o = rem_q;

endmodule

// File: rtl/intcalc_multicycle.sv
// Multi-cycle integer unit: pipelined multiply, iterative divide, unary ops.
// Ports: clk_i, rst_i (async low), in_valid_i/in_ready_o, func_i, a_i, b_i,
//        out_valid_o/out_ready_i, result_o, divz_o (divide by zero).
module intcalc_multicycle
    import bexkat1Def::*;
#(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  intfunc_t         func_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] result_o,
    output logic             divz_o
);

    generate
        if (WIDTH < 16 || WIDTH > 64) begin : g_bad_width
            $error("intcalc_multicycle: WIDTH must be 16..64");
        end
        if (MUL_LAT < 1 || MUL_LAT > 4) begin : g_bad_lat
            $error("intcalc_multicycle: MUL_LAT must be 1..4");
        end
    endgenerate

    localparam int PW = 2 * WIDTH;
    localparam logic [2:0] MCNT_LAST = 3'(MUL_LAT - 1);

    intcalc_state_t   state_q;
    intfunc_t         func_q;
    logic [WIDTH-1:0] result_q;
    logic             divz_q;
    logic             qneg_q;
    logic             rneg_q;
    logic [2:0]       mcnt_q;
    logic [PW-1:0]    prod_q [MUL_LAT];

    logic             is_mul;
    logic             is_div;
    logic             is_mod;
    logic             mul_signed;
    logic             div_signed;
    logic [WIDTH-1:0] res1_d;
    logic [PW-1:0]    mul_a;
    logic [PW-1:0]    mul_b;
    logic [PW-1:0]    prod_d;
    logic [PW-1:0]    prod_last;
    logic [WIDTH-1:0] mul_res;
    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;
    logic             b_zero;
    logic             accept;
    logic             div_start;
    logic             div_busy;
    logic             div_done;
    logic [WIDTH-1:0] div_quo;
    logic [WIDTH-1:0] div_rem;
    logic             mod_q;
    logic             hi_q;

    always_comb begin
        is_mul     = 1'b0;
        is_div     = 1'b0;
        is_mod     = 1'b0;
        mul_signed = 1'b0;
        div_signed = 1'b0;
        res1_d     = '0;
        unique case (func_i)
            INT_MUL, INT_MULX: begin
                is_mul     = 1'b1;
                mul_signed = 1'b1;
            end
            INT_MULU, INT_MULUX: is_mul = 1'b1;
            INT_DIV: begin
                is_div     = 1'b1;
                div_signed = 1'b1;
            end
            INT_MOD: begin
                is_div     = 1'b1;
                is_mod     = 1'b1;
                div_signed = 1'b1;
            end
            INT_DIVU: is_div = 1'b1;
            INT_MODU: begin
                is_div = 1'b1;
                is_mod = 1'b1;
            end
            INT_EXT:  res1_d = {{(WIDTH-16){b_i[15]}}, b_i[15:0]};
            INT_EXTB: res1_d = {{(WIDTH-8){b_i[7]}}, b_i[7:0]};
            INT_COM:  res1_d = ~b_i;
            INT_NEG:  res1_d = -b_i;
            default:  res1_d = '0;
        endcase
    end

    // Extending to 2*WIDTH first makes the truncated product exact
    // for both signed and unsigned operands.
    assign mul_a  = mul_signed ? {{WIDTH{a_i[WIDTH-1]}}, a_i}
                               : {{WIDTH{1'b0}}, a_i};
    assign mul_b  = mul_signed ? {{WIDTH{b_i[WIDTH-1]}}, b_i}
                               : {{WIDTH{1'b0}}, b_i};
    assign prod_d = mul_a * mul_b;

    assign prod_last = prod_q[MUL_LAT-1];
    assign hi_q      = (func_q == INT_MULX) || (func_q == INT_MULUX);
    assign mul_res   = hi_q ? prod_last[PW-1:WIDTH] : prod_last[WIDTH-1:0];

    // |MIN| is 2^(WIDTH-1), which is representable as unsigned.
    assign a_abs  = (div_signed && a_i[WIDTH-1]) ? -a_i : a_i;
    assign b_abs  = (div_signed && b_i[WIDTH-1]) ? -b_i : b_i;
    assign b_zero = (b_i == '0);

    assign accept    = in_valid_i && (state_q == IDLE);
    assign div_start = accept && is_div && !b_zero;
    assign mod_q     = (func_q == INT_MOD) || (func_q == INT_MODU);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < MUL_LAT; i++) begin
                prod_q[i] <= '0;
            end
        end else begin
            if (accept && is_mul) begin
                prod_q[0] <= prod_d;
            end
            for (int i = 1; i < MUL_LAT; i++) begin
                prod_q[i] <= prod_q[i-1];
            end
        end
    end

    intcalc_divider #(
        .WIDTH(WIDTH)
    ) u_div (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (div_start),
        .dividend_i  (a_abs),
        .divisor_i   (b_abs),
        .busy_o      (div_busy),
        .done_o      (div_done),
        .quotient_o  (div_quo),
        .remainder_o (div_rem)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= IDLE;
            func_q   <= INT_MUL;
            result_q <= '0;
            divz_q   <= 1'b0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            mcnt_q   <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid_i) begin
                        func_q <= func_i;
                        divz_q <= 1'b0;
                        mcnt_q <= '0;
                        qneg_q <= div_signed && (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
                        rneg_q <= div_signed && a_i[WIDTH-1];
                        if (is_mul) begin
                            state_q <= MUL;
                        end else if (is_div && b_zero) begin
                            result_q <= is_mod ? a_i : '1;
                            divz_q   <= 1'b1;
                            state_q  <= DONE;
                        end else if (is_div) begin
                            state_q <= DIV;
                        end else begin
                            result_q <= res1_d;
                            state_q  <= DONE;
                        end
                    end
                end
                MUL: begin
                    if (mcnt_q == MCNT_LAST) begin
                        result_q <= mul_res;
                        state_q  <= DONE;
                    end else begin
                        mcnt_q <= mcnt_q + 1'b1;
                    end
                end
                DIV: begin
                    if (div_busy && div_done) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    if (mod_q) begin
                        result_q <= rneg_q ? -div_rem : div_rem;
                    end else begin
                        result_q <= qneg_q ? -div_quo : div_quo;
                    end
                    state_q <= DONE;
                end
                DONE: begin
                    if (out_ready_i) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready_o  = (state_q == IDLE);
    assign out_valid_o = (state_q == DONE);
    assign result_o    = result_q;
    assign divz_o      = divz_q;

endmodule

// File: tb/tb_intcalc_multicycle.sv
// Directed bench for intcalc_multicycle (WIDTH=32, MUL_LAT=2).
module tb_intcalc_multicycle;
    import bexkat1Def::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    intfunc_t    func = INT_MUL;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic        divz;

    int checks = 0;
    int errors = 0;

    intcalc_multicycle #(
        .WIDTH(32),
        .MUL_LAT(2)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .func_i      (func),
        .a_i         (a),
        .b_i         (b),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .result_o    (result),
        .divz_o      (divz)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic issue(input string tag, input intfunc_t f,
                         input logic [31:0] av, input logic [31:0] bv);
        chk({tag, "_ready_before"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        func = f;
        a = av;
        b = bv;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = $urandom;
        b = $urandom;
        func = INT_NEG;
    endtask

    task automatic release_out(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, "_idle_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_idle_valid"}, 32'(out_valid), 32'd0);
    endtask

    task automatic run(input string tag, input intfunc_t f,
                       input logic [31:0] av, input logic [31:0] bv,
                       input logic [31:0] exp_r, input logic exp_z,
                       input int exp_lat, input bit rel);
        int lat;
        bit rdy_seen;
        issue(tag, f, av, bv);
        lat = 1;
        rdy_seen = 1'b0;
        while (!out_valid && lat < 200) begin
            if (in_ready) rdy_seen = 1'b1;
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_result"}, result, exp_r);
        chk({tag, "_divz"}, 32'(divz), 32'(exp_z));
        chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_busy_ready"}, 32'(rdy_seen), 32'd0);
        if (rel) release_out(tag);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_divz", 32'(divz), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // unsigned divide, WIDTH+2 latency
        run("divu", INT_DIVU, 32'd100, 32'd7, 32'd14, 1'b0, 34, 1'b1);
        run("modu", INT_MODU, 32'd100, 32'd7, 32'd2, 1'b0, 34, 1'b1);

        // signed divide, truncation toward zero
        run("div_neg", INT_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 1'b0, 34, 1'b1);
        run("mod_neg", INT_MOD, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 1'b0, 34, 1'b1);
        run("div_pn", INT_DIV, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0, 34, 1'b1);
        run("mod_pn", INT_MOD, 32'd7, 32'hFFFFFFFE, 32'd1, 1'b0, 34, 1'b1);
        run("div_min", INT_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 34, 1'b1);
        run("mod_min", INT_MOD, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1'b0, 34, 1'b1);
        run("divu_big", INT_DIVU, 32'hFFFFFFFF, 32'h10, 32'h0FFFFFFF, 1'b0, 34, 1'b1);

        // divide by zero
        run("divu_z", INT_DIVU, 32'd5, 32'd0, 32'hFFFFFFFF, 1'b1, 1, 1'b1);
        run("modu_z", INT_MODU, 32'd5, 32'd0, 32'd5, 1'b1, 1, 1'b1);
        run("mod_z", INT_MOD, 32'hFFFFFFF0, 32'd0, 32'hFFFFFFF0, 1'b1, 1, 1'b1);

        // multiply, latency 1+MUL_LAT
        run("mulx", INT_MULX, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 1'b0, 3, 1'b1);
        run("mulux", INT_MULUX, 32'hFFFFFFFF, 32'd2, 32'd1, 1'b0, 3, 1'b1);
        run("mul", INT_MUL, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFEB, 1'b0, 3, 1'b1);
        run("mulu", INT_MULU, 32'h00010001, 32'h00010001, 32'h00020001, 1'b0, 3, 1'b1);

        // single-cycle ops
        run("ext", INT_EXT, 32'd0, 32'h12348000, 32'hFFFF8000, 1'b0, 1, 1'b1);
        run("ext_pos", INT_EXT, 32'd0, 32'hABCD7FFF, 32'h00007FFF, 1'b0, 1, 1'b1);
        run("com", INT_COM, 32'd0, 32'h0F0F0F0F, 32'hF0F0F0F0, 1'b0, 1, 1'b1);
        run("neg", INT_NEG, 32'd0, 32'd5, 32'hFFFFFFFB, 1'b0, 1, 1'b1);
        run("unknown", intfunc_t'(4'hF), 32'd9, 32'd9, 32'd0, 1'b0, 1, 1'b1);

        // back-pressure
        run("bp", INT_DIVU, 32'd5, 32'd0, 32'hFFFFFFFF, 1'b1, 1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            func = INT_NEG;
            b = 32'(i + 1);
            @(posedge clk);
            #1;
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
            chk("bp_hold_result", result, 32'hFFFFFFFF);
            chk("bp_hold_divz", 32'(divz), 32'd1);
        end
        in_valid = 1'b0;
        release_out("bp");

        // async reset during a divide
        issue("rst_mid", INT_DIVU, 32'd100, 32'd7);
        repeat (5) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("rst_mid_ready", 32'(in_ready), 32'd1);
        chk("rst_mid_valid", 32'(out_valid), 32'd0);
        chk("rst_mid_result", result, 32'd0);
        chk("rst_mid_divz", 32'(divz), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid) break;
        end
        chk("rst_mid_no_out", 32'(out_valid), 32'd0);
        run("extb", INT_EXTB, 32'd0, 32'h00000080, 32'hFFFFFF80, 1'b0, 1, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
